// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-index serializer.
package bit_serial_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_index_map.sv
// Maps the logical bit counter onto the physical bit position in the word.
module bit_index_map #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W    = $clog2(DATA_W)
) (
    input  logic [IDX_W-1:0] i_cnt,
    output logic [IDX_W-1:0] o_index
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(DATA_W - 1);

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign o_index = LAST_POS - i_cnt;
        end else begin : g_lsb
            assign o_index = i_cnt;
        end
    endgenerate

endmodule

// File: rtl/bit_index_serializer.sv
// Parallel-to-serial shifter with a ready/valid load side and a bit strobe.
// Every output is a register; the next values are computed from the
// next-state view so the first bit shows up the cycle after acceptance.
module bit_index_serializer
    import bit_serial_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W    = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic              i_bit_tick,
    output logic              o_serial_out,
    output logic [IDX_W-1:0]  o_bit_index,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(DATA_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [DATA_W-1:0]  r_word;
    logic [DATA_W-1:0]  w_word_nxt;
    logic               w_last;

    logic               r_serial;
    logic [IDX_W-1:0]   r_index;
    logic               r_busy;
    logic               r_ready;
    logic               r_done;
    logic               w_serial_nxt;
    logic [IDX_W-1:0]   w_index_nxt;
    logic               w_busy_nxt;
    logic               w_ready_nxt;
    logic               w_done_nxt;

    // Final tick of the word: counter sits on the last logical bit.
    assign w_last = (r_state == SHIFT) && i_bit_tick && (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic: load moves to SHIFT, tick on the last bit returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_load_valid) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)       w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next counter/word: capture on load, step on tick, hold the word while shifting.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_word_nxt = r_word;
        case (r_state)
            IDLE: begin
                if (i_load_valid) begin
                    w_word_nxt = i_data_in;
                    w_cnt_nxt  = '0;
                end
            end
            SHIFT: begin
                if (i_bit_tick) begin
                    if (r_cnt == LAST_CNT) w_cnt_nxt = '0;
                    else                   w_cnt_nxt = r_cnt + IDX_W'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    bit_index_map #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_map (
        .i_cnt   (w_cnt_nxt),
        .o_index (w_idx_nxt)
    );

    // Output decode from the upcoming state so the registers line up with it.
    always_comb begin
        w_busy_nxt   = (w_state_nxt == SHIFT);
        w_ready_nxt  = (w_state_nxt == IDLE);
        w_done_nxt   = w_last;
        w_index_nxt  = w_busy_nxt ? w_idx_nxt : '0;
        w_serial_nxt = w_busy_nxt ? w_word_nxt[w_idx_nxt] : 1'b1;
    end

    // Counter and captured word registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_word <= w_word_nxt;
        end
    end

    // Registered outputs; reset values match the idle line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_serial <= 1'b1;
            r_index  <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_serial <= w_serial_nxt;
            r_index  <= w_index_nxt;
            r_busy   <= w_busy_nxt;
            r_ready  <= w_ready_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign o_serial_out = r_serial;
    assign o_bit_index  = r_index;
    assign o_busy       = r_busy;
    assign o_load_ready = r_ready;
    assign o_done       = r_done;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed bench: three instances (8b LSB-first, 8b MSB-first, 12b LSB-first).
module tb_bit_index_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // instance a: DATA_W=8, LSB first
    logic [7:0]  din_a;
    logic        vld_a, tck_a, rdy_a, so_a, bsy_a, dn_a;
    logic [2:0]  ix_a;
    // instance b: DATA_W=8, MSB first
    logic [7:0]  din_b;
    logic        vld_b, tck_b, rdy_b, so_b, bsy_b, dn_b;
    logic [2:0]  ix_b;
    // instance c: DATA_W=12, LSB first
    logic [11:0] din_c;
    logic        vld_c, tck_c, rdy_c, so_c, bsy_c, dn_c;
    logic [3:0]  ix_c;

    bit_index_serializer #(.DATA_W(8), .MSB_FIRST(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_data_in(din_a), .i_load_valid(vld_a),
        .o_load_ready(rdy_a), .i_bit_tick(tck_a), .o_serial_out(so_a),
        .o_bit_index(ix_a), .o_busy(bsy_a), .o_done(dn_a));

    bit_index_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_data_in(din_b), .i_load_valid(vld_b),
        .o_load_ready(rdy_b), .i_bit_tick(tck_b), .o_serial_out(so_b),
        .o_bit_index(ix_b), .o_busy(bsy_b), .o_done(dn_b));

    bit_index_serializer #(.DATA_W(12), .MSB_FIRST(0)) u_c (
        .i_clk(clk), .i_reset(rst), .i_data_in(din_c), .i_load_valid(vld_c),
        .o_load_ready(rdy_c), .i_bit_tick(tck_c), .o_serial_out(so_c),
        .o_bit_index(ix_c), .o_busy(bsy_c), .o_done(dn_c));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic t, input logic [11:0] d);
        case (sel)
            0:       begin vld_a = v; tck_a = t; din_a = d[7:0]; end
            1:       begin vld_b = v; tck_b = t; din_b = d[7:0]; end
            default: begin vld_c = v; tck_c = t; din_c = d;      end
        endcase
    endtask

    task automatic sample(input int sel, output logic s, output logic [3:0] ix,
                          output logic b, output logic r, output logic d);
        case (sel)
            0:       begin s = so_a; ix = {1'b0, ix_a}; b = bsy_a; r = rdy_a; d = dn_a; end
            1:       begin s = so_b; ix = {1'b0, ix_b}; b = bsy_b; r = rdy_b; d = dn_b; end
            default: begin s = so_c; ix = ix_c;         b = bsy_c; r = rdy_c; d = dn_c; end
        endcase
    endtask

    task automatic check_idle(input int sel, input string nm);
        logic s, b, r, d;
        logic [3:0] ix;
        sample(sel, s, ix, b, r, d);
        check({nm, "_serial"}, 64'(s),  64'd1);
        check({nm, "_idx"},    64'(ix), 64'd0);
        check({nm, "_busy"},   64'(b),  64'd0);
        check({nm, "_ready"},  64'(r),  64'd1);
        check({nm, "_done"},   64'(d),  64'd0);
    endtask

    // Present one word on the load port for one edge.
    task automatic offer(input int sel, input logic [11:0] data);
        drive(sel, 1'b1, 1'b0, data);
        step();
        drive(sel, 1'b0, 1'b0, 12'h0);
    endtask

    // Walk a word already accepted; ends in the done cycle.
    task automatic shift_word(input int sel, input int w, input logic [11:0] data,
                              input int msb, input int gap, input bit noise, input string nm);
        logic s, b, r, d;
        logic [3:0] ix;
        int pos;
        for (int i = 0; i < w; i++) begin
            pos = (msb != 0) ? (w - 1 - i) : i;
            sample(sel, s, ix, b, r, d);
            check($sformatf("%s_bit%0d", nm, i),  64'(s),  64'(data[pos]));
            check($sformatf("%s_idx%0d", nm, i),  64'(ix), 64'(pos));
            check($sformatf("%s_busy%0d", nm, i), 64'(b),  64'd1);
            check($sformatf("%s_done%0d", nm, i), 64'(d),  64'd0);
            for (int g = 0; g < gap; g++) begin
                if (noise) drive(sel, 1'($urandom_range(0, 1)), 1'b0, 12'($urandom));
                else       drive(sel, 1'b0, 1'b0, 12'h0);
                step();
                sample(sel, s, ix, b, r, d);
                check($sformatf("%s_hold%0d_%0d", nm, i, g), 64'(s), 64'(data[pos]));
            end
            if (noise) drive(sel, 1'($urandom_range(0, 1)), 1'b1, 12'($urandom));
            else       drive(sel, 1'b0, 1'b1, 12'h0);
            step();
        end
        drive(sel, 1'b0, 1'b0, 12'h0);
        sample(sel, s, ix, b, r, d);
        check({nm, "_done"},  64'(d),  64'd1);
        check({nm, "_dbusy"}, 64'(b),  64'd0);
        check({nm, "_drdy"},  64'(r),  64'd1);
        check({nm, "_dser"},  64'(s),  64'd1);
        check({nm, "_didx"},  64'(ix), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic s, b, r, d;
        logic [3:0] ix;
        longint t0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 12'h0);
        step();
        step();
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        check_idle(2, "rst_c");
        rst = 1'b0;

        // LSB-first A5, tick every 4 cycles; accepted on first edge after reset
        offer(0, 12'h0A5);
        shift_word(0, 8, 12'h0A5, 0, 3, 1'b0, "lsb_a5");
        step();
        check_idle(0, "lsb_after");

        // MSB-first A5
        offer(1, 12'h0A5);
        shift_word(1, 8, 12'h0A5, 1, 3, 1'b0, "msb_a5");
        step();
        check_idle(1, "msb_after");

        // back-to-back: FF offered in the done cycle of 00
        offer(0, 12'h000);
        shift_word(0, 8, 12'h000, 0, 1, 1'b0, "b2b_00");
        offer(0, 12'h0FF);
        sample(0, s, ix, b, r, d);
        check("b2b_nogap_busy", 64'(b), 64'd1);
        shift_word(0, 8, 12'h0FF, 0, 1, 1'b0, "b2b_ff");
        step();
        check_idle(0, "b2b_after");

        // reset mid-word after 3 ticks of 3C
        offer(0, 12'h03C);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b1, 12'h0);
            step();
            drive(0, 1'b0, 1'b0, 12'h0);
            step();
        end
        sample(0, s, ix, b, r, d);
        check("mid_bit3", 64'(s),  64'd1);
        check("mid_idx3", 64'(ix), 64'd3);
        #2 rst = 1'b1;
        #1 check_idle(0, "mid_rst");
        step();
        check_idle(0, "mid_rst_hold");
        rst = 1'b0;
        offer(0, 12'h002);
        shift_word(0, 8, 12'h002, 0, 0, 1'b0, "post_rst");
        step();
        check_idle(0, "post_rst_after");

        // tick in idle has no effect; then 12-bit word with tick held high
        drive(2, 1'b0, 1'b1, 12'h0);
        repeat (3) step();
        check_idle(2, "idle_tick");
        offer(2, 12'hB37);
        t0 = $time;
        shift_word(2, 12, 12'hB37, 0, 0, 1'b0, "w12");
        check("w12_cycles", 64'(($time - t0) / 10), 64'd12);
        step();
        check_idle(2, "w12_after");

        // load_valid/data noise during shift on MSB-first instance
        offer(1, 12'h05A);
        shift_word(1, 8, 12'h05A, 1, 2, 1'b1, "noise");
        step();
        check_idle(1, "noise_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_index_serializer.md
BIT_INDEX_SERIALIZER -- requirements
Module: bit_index_serializer

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 0; 0 = LSB transmitted first, 1 = MSB transmitted first.
REQ-003 Localparam IDX_W = $clog2(DATA_W), width of the index outputs.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  DATA_W  parallel word to serialise.
REQ-007 load_valid  input  1  data_in is valid this cycle.
REQ-008 load_ready  output  1  block accepts a word this cycle.
REQ-009 bit_tick  input  1  one-cycle strobe that advances to the next bit.
REQ-010 serial_out  output  1  current serial bit; 1 when idle.
REQ-011 bit_index  output  IDX_W  physical position in the captured word of the bit currently on serial_out.
REQ-012 busy  output  1  high while a word is being shifted.
REQ-013 done  output  1  one-cycle pulse after the last bit completes.

Function
REQ-014 FSM states: IDLE, SHIFT; no other states are reachable.
REQ-015 IDLE: load_ready=1, busy=0, serial_out=1, bit_index=0.
REQ-016 Handshake: a transfer occurs when load_valid && load_ready at a rising edge; data_in is captured into an internal DATA_W register, the logical counter is cleared to 0, and the state becomes SHIFT.
REQ-017 SHIFT: load_ready=0, busy=1; load_valid is ignored and the captured word is held stable.
REQ-018 Logical counter cnt (0..DATA_W-1) maps to physical position: bit_index = cnt if MSB_FIRST=0, otherwise DATA_W-1-cnt.
REQ-019 In SHIFT, serial_out = captured_word[bit_index]; the first bit is presented in the cycle after acceptance (latency 1).
REQ-020 In SHIFT, bit_tick with cnt < DATA_W-1 increments cnt by 1; the next bit appears in the following cycle.
REQ-021 In SHIFT, bit_tick with cnt = DATA_W-1 sets state to IDLE and asserts done for exactly one cycle; cnt does not wrap to 0 while in SHIFT.
REQ-022 bit_tick in IDLE has no effect.
REQ-023 Back-to-back transfers: a word offered in the cycle done is high is accepted, because load_ready is already 1 in that cycle.
REQ-024 bit_tick held high for consecutive cycles advances one bit per cycle, with no skipped or repeated bit.
REQ-025 serial_out, bit_index, busy, load_ready and done are driven from registers only; there is no combinational path from any input.

Reset
REQ-026 Asserting reset at any time, including mid-word, forces IDLE, cnt=0, captured word=0, done=0 and serial_out=1, with no glitch after deassertion.
REQ-027 The first transfer can be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Package bit_serial_pkg holds the state enum typedef (IDLE, SHIFT) and the DATA_W default constant.
REQ-029 Sub-module bit_index_map converts cnt to a physical position and is parametrised by DATA_W and MSB_FIRST.
REQ-030 Estimated RTL size: 120-250 lines in total.

Verification
REQ-031 DATA_W=8, MSB_FIRST=0, load 8'hA5, tick every 4 cycles -> serial_out 1,0,1,0,0,1,0,1; bit_index 0..7; one done pulse.
REQ-032 DATA_W=8, MSB_FIRST=1, load 8'hA5 -> serial_out 1,0,1,0,0,1,0,1; bit_index 7..0.
REQ-033 Re-assert load_valid with 8'hFF in the done cycle after 8'h00 -> 8'hFF accepted with no idle gap; second done after 8 further ticks.
REQ-034 Assert reset after 3 ticks of 8'h3C -> serial_out=1, busy=0, load_ready=1, bit_index=0 the same cycle; no done pulse.
REQ-035 DATA_W=12, bit_tick held high continuously -> 12 consecutive bits, done 12 cycles after the first bit.
REQ-036 load_valid toggled with random data during SHIFT -> captured word unchanged and no extra transfer.
